// File: rtl/ssd1306_pkg.sv
// Shared constants for the SSD1306 SPI responder: opcodes, argument classes
// and the command parser state encoding.
package ssd1306_pkg;

    localparam logic [7:0] CMD_ADDR_MODE = 8'h20;
    localparam logic [7:0] CMD_SET_COL   = 8'h21;
    localparam logic [7:0] CMD_SET_PAGE  = 8'h22;
    localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
    localparam logic [7:0] CMD_DISP_ON   = 8'hAF;

    // Parser state encoding; the parser register is typed parser_state_t.
    typedef logic [1:0] parser_state_t;
    localparam parser_state_t P_IDLE = 2'd0;
    localparam parser_state_t P_ARG1 = 2'd1;
    localparam parser_state_t P_ARG2 = 2'd2;
    localparam parser_state_t P_SKIP = 2'd3;

    // Opcodes followed by exactly one argument byte that we do not model.
    function automatic logic is_single_arg(input logic [7:0] op);
        case (op)
            8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
            8'hD5, 8'hD9, 8'hDA, 8'hDB: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ssd1306_spi_rx.sv
// SPI mode-0 byte receiver: synchronizes the four pins, detects rising SCK
// and assembles MSB-first bytes, tagging each with its DC level.
module ssd1306_spi_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pin_csn,
    input  logic       pin_dc,
    input  logic       pin_sck,
    input  logic       pin_mosi,
    output logic       byte_stb,
    output logic [7:0] byte_data,
    output logic       byte_dc
);

    logic [1:0] csn_sync;
    logic [1:0] dc_sync;
    logic [1:0] sck_sync;
    logic [1:0] mosi_sync;
    logic       sck_prev;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic       sck_rise;

    // CS# synchronizer resets to "deselected" so no SCK edge is honoured
    // until CS# has actually been seen low after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csn_sync  <= 2'b11;
            dc_sync   <= 2'b00;
            sck_sync  <= 2'b00;
            mosi_sync <= 2'b00;
            sck_prev  <= 1'b0;
        end else begin
            csn_sync  <= {csn_sync[0], pin_csn};
            dc_sync   <= {dc_sync[0], pin_dc};
            sck_sync  <= {sck_sync[0], pin_sck};
            mosi_sync <= {mosi_sync[0], pin_mosi};
            sck_prev  <= sck_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 3'd0;
            shift     <= 7'd0;
            byte_stb  <= 1'b0;
            byte_data <= 8'd0;
            byte_dc   <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            if (csn_sync[1]) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                if (bit_cnt == 3'd7) begin
                    byte_data <= {shift, mosi_sync[1]};
                    byte_dc   <= dc_sync[1];
                    byte_stb  <= 1'b1;
                    bit_cnt   <= 3'd0;
                end else begin
                    shift   <= {shift[5:0], mosi_sync[1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ssd1306_spi_sink.sv
// Display-side model of the SSD1306 SPI link: parses the command stream and
// turns data bytes into addressed framebuffer writes (horizontal mode only).
module ssd1306_spi_sink
    import ssd1306_pkg::*;
#(
    parameter int COLUMNS = 128,
    parameter int PAGES   = 4,
    parameter int ADDR_W  = $clog2(COLUMNS * PAGES)
) (
    input  logic              clk_in,
    input  logic              resetn_in,
    input  logic              oled_csn_in,
    input  logic              oled_dc_in,
    input  logic              oled_clk_in,
    input  logic              oled_mosi_in,
    output logic              fb_we_out,
    output logic [ADDR_W-1:0] fb_addr_out,
    output logic [7:0]        fb_data_out,
    output logic              cmd_stb_out,
    output logic [7:0]        cmd_out,
    output logic              display_on_out
);

    localparam int CW = $clog2(COLUMNS);
    localparam int PW = $clog2(PAGES);

    logic          byte_stb;
    logic [7:0]    byte_data;
    logic          byte_dc;

    parser_state_t parser_state;
    logic [7:0]    pending_op;
    logic [CW-1:0] arg_col;
    logic [PW-1:0] arg_page;
    logic [CW-1:0] col_start, col_end, col_ptr;
    logic [PW-1:0] page_start, page_end, page_ptr;

    ssd1306_spi_rx u_rx (
        .clk       (clk_in),
        .rst_n     (resetn_in),
        .pin_csn   (oled_csn_in),
        .pin_dc    (oled_dc_in),
        .pin_sck   (oled_clk_in),
        .pin_mosi  (oled_mosi_in),
        .byte_stb  (byte_stb),
        .byte_data (byte_data),
        .byte_dc   (byte_dc)
    );

    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            parser_state   <= P_IDLE;
            pending_op     <= 8'd0;
            arg_col        <= '0;
            arg_page       <= '0;
            col_start      <= '0;
            col_end        <= CW'(COLUMNS - 1);
            col_ptr        <= '0;
            page_start     <= '0;
            page_end       <= PW'(PAGES - 1);
            page_ptr       <= '0;
            fb_we_out      <= 1'b0;
            fb_addr_out    <= '0;
            fb_data_out    <= 8'd0;
            cmd_stb_out    <= 1'b0;
            cmd_out        <= 8'd0;
            display_on_out <= 1'b0;
        end else begin
            fb_we_out   <= 1'b0;
            cmd_stb_out <= 1'b0;
            if (byte_stb) begin
                if (byte_dc) begin
                    // Data byte: always a pixel write; aborts any half-parsed command.
                    fb_we_out    <= 1'b1;
                    fb_addr_out  <= {page_ptr, col_ptr};
                    fb_data_out  <= byte_data;
                    parser_state <= P_IDLE;
                    if (col_ptr == col_end) begin
                        col_ptr  <= col_start;
                        page_ptr <= (page_ptr == page_end) ? page_start : page_ptr + PW'(1);
                    end else begin
                        col_ptr <= col_ptr + CW'(1);
                    end
                end else begin
                    case (parser_state)
                        P_IDLE: begin
                            pending_op <= byte_data;
                            if (byte_data == CMD_SET_COL || byte_data == CMD_SET_PAGE) begin
                                parser_state <= P_ARG1;
                            end else if (is_single_arg(byte_data)) begin
                                parser_state <= P_SKIP;
                            end else begin
                                cmd_stb_out <= 1'b1;
                                cmd_out     <= byte_data;
                                if (byte_data == CMD_DISP_ON)  display_on_out <= 1'b1;
                                if (byte_data == CMD_DISP_OFF) display_on_out <= 1'b0;
                            end
                        end
                        P_ARG1: begin
                            arg_col      <= byte_data[CW-1:0];
                            arg_page     <= byte_data[PW-1:0];
                            parser_state <= P_ARG2;
                        end
                        P_ARG2: begin
                            if (pending_op == CMD_SET_COL) begin
                                col_start <= arg_col;
                                col_end   <= byte_data[CW-1:0];
                                col_ptr   <= arg_col;
                            end else begin
                                page_start <= arg_page;
                                page_end   <= byte_data[PW-1:0];
                                page_ptr   <= arg_page;
                            end
                            cmd_stb_out  <= 1'b1;
                            cmd_out      <= pending_op;
                            parser_state <= P_IDLE;
                        end
                        default: begin
                            cmd_stb_out  <= 1'b1;
                            cmd_out      <= pending_op;
                            parser_state <= P_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// Directed bench for ssd1306_spi_sink: bit-bangs the OLED pins and checks every
// framebuffer write and command strobe against a queue of expected events.
module tb_ssd1306_spi_sink;

    localparam int W = 18;  // {is_cmd, addr[8:0], data/opcode[7:0]}

    logic       clk;
    logic       resetn;
    logic       csn, dc, sck, mosi;
    logic       fb_we;
    logic [8:0] fb_addr;
    logic [7:0] fb_data;
    logic       cmd_stb;
    logic [7:0] cmd;
    logic       display_on;

    logic [W-1:0] exp_q[$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int last_rise_cyc = 0;

    ssd1306_spi_sink dut (
        .clk_in         (clk),
        .resetn_in      (resetn),
        .oled_csn_in    (csn),
        .oled_dc_in     (dc),
        .oled_clk_in    (sck),
        .oled_mosi_in   (mosi),
        .fb_we_out      (fb_we),
        .fb_addr_out    (fb_addr),
        .fb_data_out    (fb_data),
        .cmd_stb_out    (cmd_stb),
        .cmd_out        (cmd),
        .display_on_out (display_on)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d, required 0", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic dcv, input logic [7:0] value, input int nbits);
        @(negedge clk);
        csn = 1'b0;
        dc  = dcv;
        wait_clks(4);
        for (int i = 0; i < nbits; i++) begin
            mosi = value[7-i];
            wait_clks(4);
            sck = 1'b1;
            if (i == 7) last_rise_cyc = cyc;
            wait_clks(4);
            sck = 1'b0;
        end
        wait_clks(4);
        csn = 1'b1;
        wait_clks(4);
    endtask

    task automatic send(input logic dcv, input logic [7:0] value);
        spi_bits(dcv, value, 8);
    endtask

    task automatic exp_write(input logic [8:0] addr, input logic [7:0] data);
        exp_q.push_back({1'b0, addr, data});
    endtask

    task automatic exp_cmd(input logic [7:0] op);
        exp_q.push_back({1'b1, 9'd0, op});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetn = 1'b0;
        wait_clks(3);
        resetn = 1'b1;
        wait_clks(3);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (fb_we || cmd_stb) begin
            logic [W-1:0] act;
            logic [W-1:0] req;
            act = fb_we ? {1'b0, fb_addr, fb_data} : {1'b1, 9'd0, cmd};
            compared++;
            if (fb_we && cmd_stb) begin
                mismatched++;
                $display("FAIL strobe_overlap: fb_we=%0b cmd_stb=%0b, required not both", fb_we, cmd_stb);
            end else if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_event: got 0x%05h, required no event", act);
            end else begin
                req = exp_q.pop_front();
                if (act !== req) begin
                    mismatched++;
                    $display("FAIL event: got 0x%05h, required 0x%05h", act, req);
                end
            end
            compared++;
            if (cyc - last_rise_cyc != 4) begin
                mismatched++;
                $display("FAIL latency: got %0d cycles, required 4", cyc - last_rise_cyc);
            end
        end
    end

    // Stimulus
    initial begin
        resetn = 1'b0;
        csn    = 1'b1;
        dc     = 1'b0;
        sck    = 1'b0;
        mosi   = 1'b0;
        wait_clks(5);
        check("reset_fb_we", 32'(fb_we), 32'd0);
        check("reset_cmd_stb", 32'(cmd_stb), 32'd0);
        check("reset_fb_addr", 32'(fb_addr), 32'd0);
        check("reset_fb_data", 32'(fb_data), 32'd0);
        check("reset_cmd", 32'(cmd), 32'd0);
        check("reset_display_on", 32'(display_on), 32'd0);
        resetn = 1'b1;
        wait_clks(5);

        // Display on
        exp_cmd(8'hAF);
        send(1'b0, 8'hAF);
        check("display_on_after_af", 32'(display_on), 32'd1);

        // Full-screen window, 513 data bytes wrap back to address 0
        exp_cmd(8'h22);
        send(1'b0, 8'h22); send(1'b0, 8'h00); send(1'b0, 8'h03);
        exp_cmd(8'h21);
        send(1'b0, 8'h21); send(1'b0, 8'h00); send(1'b0, 8'h7F);
        for (int i = 0; i < 513; i++) begin
            exp_write(9'(i % 512), 8'(i));
            send(1'b1, 8'(i));
        end

        // Small window: columns 16..17 on page 2 -> 272, 273, 272
        exp_cmd(8'h21);
        send(1'b0, 8'h21); send(1'b0, 8'h10); send(1'b0, 8'h11);
        exp_cmd(8'h22);
        send(1'b0, 8'h22); send(1'b0, 8'h02); send(1'b0, 8'h02);
        exp_write(9'd272, 8'hA1); send(1'b1, 8'hA1);
        exp_write(9'd273, 8'hA2); send(1'b1, 8'hA2);
        exp_write(9'd272, 8'hA3); send(1'b1, 8'hA3);

        // Single-arg opcode aborted by a data byte: pointer sits at 273
        send(1'b0, 8'h81);
        exp_write(9'd273, 8'h5A);
        send(1'b1, 8'h5A);

        // Display off, then a completed single-arg command
        exp_cmd(8'hAE);
        send(1'b0, 8'hAE);
        check("display_on_after_ae", 32'(display_on), 32'd0);
        send(1'b0, 8'hA8);
        exp_cmd(8'hA8);
        send(1'b0, 8'h1F);

        // Partial byte discarded by CS#; next full byte writes 272
        spi_bits(1'b1, 8'hFF, 5);
        exp_write(9'd272, 8'hC3);
        send(1'b1, 8'hC3);

        // Reset between 0x21 and its argument
        exp_cmd(8'hAF);
        send(1'b0, 8'hAF);
        check("display_on_before_reset", 32'(display_on), 32'd1);
        send(1'b0, 8'h21);
        pulse_reset();
        check("display_on_after_reset", 32'(display_on), 32'd0);
        check("fb_addr_after_reset", 32'(fb_addr), 32'd0);
        exp_cmd(8'hE3);
        send(1'b0, 8'hE3);
        exp_write(9'd0, 8'h77); send(1'b1, 8'h77);
        exp_write(9'd1, 8'h78); send(1'b1, 8'h78);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
